// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking gate controller: slot geometry,
// gate FSM states and slot-search/count functions.
package parking_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    DOOR_HOLD = 1'b1
  } gate_state_t;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_IDX_W-1:0] idx;
  } free_slot_t;

  // Scans from the top so the final hit is the lowest-index free slot.
  function automatic free_slot_t lowest_free(input logic [NUM_SLOTS-1:0] slots);
    free_slot_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i]) begin
        r.valid = 1'b1;
        r.idx   = SLOT_IDX_W'(i);
      end else begin
        r.valid = r.valid;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] free_slots(input logic [NUM_SLOTS-1:0] slots);
    logic [2:0] cnt;
    cnt = 3'(NUM_SLOTS);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots[i]) begin
        cnt = cnt - 3'd1;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/parking_gate_controller_debouncer.sv
// Two-flop synchroniser plus consecutive-sample debouncer for one raw sensor;
// emits a one-cycle pulse on each accepted rising level.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the run of mismatches.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate controller: debounced sensor events, single-depth pending
// latches, occupancy register and gate hold timing.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 400000,
  parameter int DOOR_HOLD_CYCLES = 80000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  entry_sensor,
  input  logic                  exit_sensor,
  input  logic [SLOT_IDX_W-1:0] switch,
  output logic [NUM_SLOTS-1:0]  slots,
  output logic                  door_open_pulse,
  output logic                  full_pulse,
  output logic                  invalid_exit_pulse,
  output logic                  door_busy,
  output logic [2:0]            free_count,
  output logic [SLOT_IDX_W-1:0] last_slot
);

  localparam int HOLD_W = (DOOR_HOLD_CYCLES > 1) ? $clog2(DOOR_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DOOR_HOLD_CYCLES - 1);

  logic entry_rise_s, exit_rise_s;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (entry_sensor),
    .rise_o (entry_rise_s)
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (exit_sensor),
    .rise_o (exit_rise_s)
  );

  gate_state_t           state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [NUM_SLOTS-1:0]  slots_q, slots_d;
  logic [2:0]            free_q, free_d;
  logic [SLOT_IDX_W-1:0] last_q, last_d;
  logic                  door_q, door_d;
  logic                  full_q, full_d;
  logic                  inv_q, inv_d;
  logic                  entry_pend_q, entry_pend_d;
  logic                  exit_pend_q, exit_pend_d;
  logic [SLOT_IDX_W-1:0] exit_sw_q, exit_sw_d;
  logic                  entry_srv_s, exit_srv_s;
  free_slot_t            free_sel_s;

  // Gate FSM: serves one pending event per IDLE cycle, exit before entry.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    slots_d     = slots_q;
    last_d      = last_q;
    door_d      = 1'b0;
    full_d      = 1'b0;
    inv_d       = 1'b0;
    entry_srv_s = 1'b0;
    exit_srv_s  = 1'b0;
    free_sel_s  = lowest_free(slots_q);
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (exit_pend_q) begin
          exit_srv_s = 1'b1;
          if (slots_q[exit_sw_q]) begin
            slots_d[exit_sw_q] = 1'b0;
            door_d             = 1'b1;
            last_d             = exit_sw_q;
            state_d            = DOOR_HOLD;
          end else begin
            inv_d = 1'b1;
          end
        end else if (entry_pend_q) begin
          entry_srv_s = 1'b1;
          if (free_sel_s.valid) begin
            slots_d[free_sel_s.idx] = 1'b1;
            door_d                  = 1'b1;
            last_d                  = free_sel_s.idx;
            state_d                 = DOOR_HOLD;
          end else begin
            full_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DOOR_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // A second event while the flag is still set is dropped, not queued.
  always_comb begin
    entry_pend_d = entry_pend_q ? ~entry_srv_s : entry_rise_s;
    exit_pend_d  = exit_pend_q ? ~exit_srv_s : exit_rise_s;
    if (!exit_pend_q && exit_rise_s) begin
      exit_sw_d = switch;
    end else begin
      exit_sw_d = exit_sw_q;
    end
    free_d = free_slots(slots_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      slots_q      <= '0;
      free_q       <= 3'd4;
      last_q       <= '0;
      door_q       <= 1'b0;
      full_q       <= 1'b0;
      inv_q        <= 1'b0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      exit_sw_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      slots_q      <= slots_d;
      free_q       <= free_d;
      last_q       <= last_d;
      door_q       <= door_d;
      full_q       <= full_d;
      inv_q        <= inv_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      exit_sw_q    <= exit_sw_d;
    end
  end

  assign slots              = slots_q;
  assign free_count         = free_q;
  assign last_slot          = last_q;
  assign door_open_pulse    = door_q;
  assign full_pulse         = full_q;
  assign invalid_exit_pulse = inv_q;
  assign door_busy          = (state_q == DOOR_HOLD);

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed and randomized bench for parking_gate_controller, checked every
// cycle against a behavioural model of the sensor, occupancy and gate rules.
module tb_parking_gate_controller;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] switch;
  logic [3:0] slots;
  logic       door_open_pulse;
  logic       full_pulse;
  logic       invalid_exit_pulse;
  logic       door_busy;
  logic [2:0] free_count;
  logic [1:0] last_slot;

  always #5 clk = ~clk;

  parking_gate_controller #(
    .DEBOUNCE_CYCLES  (DB),
    .DOOR_HOLD_CYCLES (HOLD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .entry_sensor       (entry_sensor),
    .exit_sensor        (exit_sensor),
    .switch             (switch),
    .slots              (slots),
    .door_open_pulse    (door_open_pulse),
    .full_pulse         (full_pulse),
    .invalid_exit_pulse (invalid_exit_pulse),
    .door_busy          (door_busy),
    .free_count         (free_count),
    .last_slot          (last_slot)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  // Behavioural model state: index 0 = entry sensor, 1 = exit sensor.
  bit samp [2][MAXC];
  int m_last_flip [2];
  bit m_d1 [2];
  bit m_d2 [2];
  bit m_level [2];
  bit m_rise [2];
  bit m_pend [2];
  int m_sw;
  int m_slot [4];
  int m_last;
  int m_busy_left;
  bit m_door, m_full, m_inv;

  int obs_door = 0, obs_full = 0, obs_inv = 0, obs_busy = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic int m_slots_word();
    int w = 0;
    for (int i = 0; i < 4; i++) w += m_slot[i] << i;
    return w;
  endfunction

  function automatic int m_free();
    int f = 0;
    for (int i = 0; i < 4; i++) if (m_slot[i] == 0) f++;
    return f;
  endfunction

  task automatic model_step();
    bit srv [2];
    bit raw [2];
    raw[0] = entry_sensor;
    raw[1] = exit_sensor;
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        m_last_flip[s] = k;
        m_d1[s] = 0; m_d2[s] = 0; m_level[s] = 0; m_rise[s] = 0; m_pend[s] = 0;
      end
      for (int i = 0; i < 4; i++) m_slot[i] = 0;
      m_sw = 0; m_last = 0; m_busy_left = 0;
      m_door = 0; m_full = 0; m_inv = 0;
    end else begin
      m_door = 0; m_full = 0; m_inv = 0;
      srv[0] = 0; srv[1] = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (m_pend[1]) begin
        srv[1] = 1;
        if (m_slot[m_sw] == 1) begin
          m_slot[m_sw] = 0; m_door = 1; m_last = m_sw; m_busy_left = HOLD;
        end else begin
          m_inv = 1;
        end
      end else if (m_pend[0]) begin
        int found = -1;
        srv[0] = 1;
        for (int i = 3; i >= 0; i--) if (m_slot[i] == 0) found = i;
        if (found >= 0) begin
          m_slot[found] = 1; m_door = 1; m_last = found; m_busy_left = HOLD;
        end else begin
          m_full = 1;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (m_pend[s]) begin
          m_pend[s] = !srv[s];
        end else begin
          m_pend[s] = m_rise[s];
          if (s == 1 && m_rise[1]) m_sw = int'(switch);
        end
      end
      for (int s = 0; s < 2; s++) begin
        bit all_diff;
        samp[s][k] = m_d2[s];
        m_d2[s] = m_d1[s];
        m_d1[s] = raw[s];
        all_diff = (k - m_last_flip[s] >= DB);
        if (all_diff) for (int j = 0; j < DB; j++) if (samp[s][k-j] == m_level[s]) all_diff = 0;
        m_rise[s] = all_diff && !m_level[s];
        if (all_diff) begin
          m_level[s] = !m_level[s];
          m_last_flip[s] = k;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("slots", 32'(slots), 32'(m_slots_word()));
    check_eq("free_count", 32'(free_count), 32'(m_free()));
    check_eq("last_slot", 32'(last_slot), 32'(m_last));
    check_eq("door_open_pulse", 32'(door_open_pulse), 32'(m_door));
    check_eq("full_pulse", 32'(full_pulse), 32'(m_full));
    check_eq("invalid_exit_pulse", 32'(invalid_exit_pulse), 32'(m_inv));
    check_eq("door_busy", 32'(door_busy), 32'(m_busy_left > 0));
    obs_door += int'(door_open_pulse);
    obs_full += int'(full_pulse);
    obs_inv  += int'(invalid_exit_pulse);
    obs_busy += int'(door_busy);
    k++;
  endtask

  task automatic drive_for(input bit e, input bit x, input int sw, input int n);
    entry_sensor = e;
    exit_sensor  = x;
    switch       = 2'(sw);
    repeat (n) cycle();
  endtask

  task automatic clean_event(input bit e, input bit x, input int sw);
    drive_for(e, x, sw, 10);
    drive_for(1'b0, 1'b0, sw, 10);
  endtask

  task automatic do_reset();
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int d0, f0, i0, b0;
    reset = 1'b1; entry_sensor = 1'b0; exit_sensor = 1'b0; switch = 2'd0;
    cycle();
    cycle();
    reset = 1'b0;
    check_eq("reset_free", 32'(free_count), 32'd4);
    check_eq("reset_slots", 32'(slots), 32'd0);

    // Bounce: toggling every 2 cycles never accepts a level.
    d0 = obs_door;
    for (int i = 0; i < 10; i++) drive_for(bit'((i % 2) == 0), 1'b0, 0, 2);
    drive_for(1'b0, 1'b0, 0, 4);
    check_eq("bounce_slots", 32'(slots), 32'd0);
    check_eq("bounce_pulses", 32'(obs_door - d0), 32'd0);

    d0 = obs_door; b0 = obs_busy;
    clean_event(1'b1, 1'b0, 0);
    check_eq("first_entry_slots", 32'(slots), 32'h1);
    check_eq("first_entry_last", 32'(last_slot), 32'd0);
    check_eq("first_entry_pulses", 32'(obs_door - d0), 32'd1);
    check_eq("first_entry_busy_len", 32'(obs_busy - b0), 32'(HOLD));

    // Fill and refuse.
    do_reset();
    d0 = obs_door; f0 = obs_full;
    for (int i = 0; i < 5; i++) clean_event(1'b1, 1'b0, 0);
    check_eq("fill_slots", 32'(slots), 32'hF);
    check_eq("fill_free", 32'(free_count), 32'd0);
    check_eq("fill_door_pulses", 32'(obs_door - d0), 32'd4);
    check_eq("fill_full_pulses", 32'(obs_full - f0), 32'd1);

    // Exit and reuse.
    clean_event(1'b0, 1'b1, 2);
    check_eq("exit2_slots", 32'(slots), 32'hB);
    check_eq("exit2_last", 32'(last_slot), 32'd2);
    clean_event(1'b1, 1'b0, 0);
    check_eq("reuse_slots", 32'(slots), 32'hF);
    check_eq("reuse_last", 32'(last_slot), 32'd2);

    // Invalid exit.
    do_reset();
    clean_event(1'b1, 1'b0, 0);
    i0 = obs_inv; b0 = obs_busy;
    clean_event(1'b0, 1'b1, 3);
    check_eq("inv_pulses", 32'(obs_inv - i0), 32'd1);
    check_eq("inv_slots", 32'(slots), 32'h1);
    check_eq("inv_busy", 32'(obs_busy - b0), 32'd0);

    // Simultaneous entry and exit.
    do_reset();
    clean_event(1'b1, 1'b0, 0);
    clean_event(1'b1, 1'b0, 0);
    d0 = obs_door;
    drive_for(1'b1, 1'b1, 0, 10);
    check_eq("simul_exit_slots", 32'(slots), 32'h2);
    drive_for(1'b0, 1'b0, 0, 10);
    check_eq("simul_entry_slots", 32'(slots), 32'h3);
    check_eq("simul_pulses", 32'(obs_door - d0), 32'd2);

    // Reset during hold.
    do_reset();
    drive_for(1'b1, 1'b0, 0, 10);
    check_eq("hold_busy_before_reset", 32'(door_busy), 32'd1);
    do_reset();
    check_eq("hold_rst_slots", 32'(slots), 32'd0);
    check_eq("hold_rst_free", 32'(free_count), 32'd4);
    check_eq("hold_rst_busy", 32'(door_busy), 32'd0);
    check_eq("hold_rst_last", 32'(last_slot), 32'd0);
    drive_for(1'b0, 1'b0, 0, 10);

    // Randomized sensor activity with occasional resets.
    while (k < 6000) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        drive_for(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 14)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
